// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions
// and the active-high segment patterns for BCD digits and the dash glyph.
package seg7_pkg;

    localparam int SEG_A_IDX = 0;
    localparam int SEG_B_IDX = 1;
    localparam int SEG_C_IDX = 2;
    localparam int SEG_D_IDX = 3;
    localparam int SEG_E_IDX = 4;
    localparam int SEG_F_IDX = 5;
    localparam int SEG_G_IDX = 6;

    localparam logic [6:0] SEG_A = 7'(1 << SEG_A_IDX);
    localparam logic [6:0] SEG_B = 7'(1 << SEG_B_IDX);
    localparam logic [6:0] SEG_C = 7'(1 << SEG_C_IDX);
    localparam logic [6:0] SEG_D = 7'(1 << SEG_D_IDX);
    localparam logic [6:0] SEG_E = 7'(1 << SEG_E_IDX);
    localparam logic [6:0] SEG_F = 7'(1 << SEG_F_IDX);
    localparam logic [6:0] SEG_G = 7'(1 << SEG_G_IDX);

    localparam logic [6:0] SEG_DIGIT_0 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
    localparam logic [6:0] SEG_DIGIT_1 = SEG_B | SEG_C;
    localparam logic [6:0] SEG_DIGIT_2 = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
    localparam logic [6:0] SEG_DIGIT_3 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
    localparam logic [6:0] SEG_DIGIT_4 = SEG_B | SEG_C | SEG_F | SEG_G;
    localparam logic [6:0] SEG_DIGIT_5 = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
    localparam logic [6:0] SEG_DIGIT_6 = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
    localparam logic [6:0] SEG_DIGIT_7 = SEG_A | SEG_B | SEG_C;
    localparam logic [6:0] SEG_DIGIT_8 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
    localparam logic [6:0] SEG_DIGIT_9 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;

    // Non-BCD codes (A..F) show a dash so a counter fault is visible.
    localparam logic [6:0] SEG_DASH  = SEG_G;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, active-high, a = bit 0.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Look up the glyph for one BCD nibble; anything above 9 becomes a dash.
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_DIGIT_0;
            4'd1:    o_seg = SEG_DIGIT_1;
            4'd2:    o_seg = SEG_DIGIT_2;
            4'd3:    o_seg = SEG_DIGIT_3;
            4'd4:    o_seg = SEG_DIGIT_4;
            4'd5:    o_seg = SEG_DIGIT_5;
            4'd6:    o_seg = SEG_DIGIT_6;
            4'd7:    o_seg = SEG_DIGIT_7;
            4'd8:    o_seg = SEG_DIGIT_8;
            4'd9:    o_seg = SEG_DIGIT_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: snapshots the BCD digit vector once
// per frame, scans one digit per slot with a dead time at the start of every
// slot, and applies leading-zero blanking, decimal points and blinking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int DEAD_CYC       = 500,
    parameter int BLINK_FRAMES   = 50,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
)(
    input  logic                  i_time_clk,
    input  logic                  i_sys_rst,
    input  logic [4*DIGITS-1:0]   i_digits,
    input  logic [DIGITS-1:0]     i_dp_mask,
    input  logic                  i_blank_lz,
    input  logic [DIGITS-1:0]     i_blink_mask,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [DIGITS-1:0]     o_dig_en,
    output logic                  o_frame_start
);

    localparam int P_W = $clog2(SCAN_DIV);
    localparam int S_W = $clog2(DIGITS);
    localparam int F_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [P_W-1:0] P_LAST = P_W'(SCAN_DIV - 1);
    localparam logic [P_W-1:0] P_DEAD = P_W'(DEAD_CYC);
    localparam logic [S_W-1:0] S_LAST = S_W'(DIGITS - 1);
    localparam logic [F_W-1:0] F_LAST = F_W'(BLINK_FRAMES - 1);

    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

    localparam logic [6:0]        SEG_OFF = {7{SEG_INV}};
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_INV}};

    logic [P_W-1:0]      p_q, p_d;
    logic [S_W-1:0]      s_q, s_d;
    logic [4*DIGITS-1:0] snap_q, snap_d;
    logic [F_W-1:0]      f_q, f_d;
    logic                b_q, b_d;
    logic                wrap_q, wrap_d;

    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   dig_en_q, dig_en_d;
    logic                frame_start_q, frame_start_d;

    logic                p_end;
    logic                s_end;
    logic                wrap;
    logic [DIGITS-1:0]   lz_mask;
    logic                zero_run;
    logic [3:0]          cur_bcd;
    logic [6:0]          dec_seg;
    logic [6:0]          seg_ah;
    logic                dp_ah;
    logic [DIGITS-1:0]   dig_ah;

    // Advance prescaler and slot; on frame wrap take a new snapshot and step the blink timer.
    always_comb begin
        p_end  = (p_q == P_LAST);
        s_end  = (s_q == S_LAST);
        wrap   = p_end && s_end;
        p_d    = p_end ? '0 : p_q + 1'b1;
        s_d    = s_q;
        snap_d = snap_q;
        f_d    = f_q;
        b_d    = b_q;
        wrap_d = wrap;
        if (p_end) begin
            s_d = s_end ? '0 : s_q + 1'b1;
        end
        if (wrap) begin
            snap_d = i_digits;
            if (f_q == F_LAST) begin
                f_d = '0;
                b_d = ~b_q;
            end else begin
                f_d = f_q + 1'b1;
            end
        end
    end

    // Mark digit k as a leading zero when it and every more significant digit are 0.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run & (snap_q[4*k +: 4] == 4'd0);
            lz_mask[k] = zero_run;
        end
    end

    assign cur_bcd = snap_q[{s_q, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .i_bcd (cur_bcd),
        .o_seg (dec_seg)
    );

    // Build the active-high display image for the current slot, then apply pin polarity.
    always_comb begin
        seg_ah = dec_seg;
        dp_ah  = i_dp_mask[s_q];
        if (i_blank_lz && lz_mask[s_q]) begin
            seg_ah = SEG_BLANK;
        end
        if (!b_q && i_blink_mask[s_q]) begin
            seg_ah = SEG_BLANK;
            dp_ah  = 1'b0;
        end
        dig_ah = (p_q >= P_DEAD) ? (DIGITS'(1) << s_q) : '0;

        seg_d         = seg_ah ^ SEG_OFF;
        dp_d          = dp_ah ^ SEG_INV;
        dig_en_d      = dig_ah ^ DIG_OFF;
        frame_start_d = wrap_q;
    end

    // Scan state registers; reset lands on slot 0 with an all-zero snapshot and blink visible.
    always_ff @(posedge i_time_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            p_q    <= '0;
            s_q    <= '0;
            snap_q <= '0;
            f_q    <= '0;
            b_q    <= 1'b1;
            wrap_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            s_q    <= s_d;
            snap_q <= snap_d;
            f_q    <= f_d;
            b_q    <= b_d;
            wrap_q <= wrap_d;
        end
    end

    // Output register stage; reset drives every pin to its inactive level.
    always_ff @(posedge i_time_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            seg_q         <= SEG_OFF;
            dp_q          <= SEG_INV;
            dig_en_q      <= DIG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            dig_en_q      <= dig_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_seg         = seg_q;
    assign o_dp          = dp_q;
    assign o_dig_en      = dig_en_q;
    assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with a small scan (4 digits, 8-cycle slots,
// 2-cycle dead time, 2-frame blink half period, active-high pins).
module tb_seg7_scan_driver;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 8;
    localparam int DEAD_CYC     = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_mask = 4'b0000;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_mask = 4'b0000;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [3:0]  o_dig_en;
    logic        o_frame_start;

    int checks = 0;
    int errors = 0;
    int cyc = -1;

    logic [6:0] seg_lut [16];

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp_mask;
        logic        blank_lz;
        int          slot;
        logic [6:0]  exp_seg;
        logic        exp_dp;
    } vec_t;

    vec_t vecs [19];

    seg7_scan_driver #(
        .DIGITS         (DIGITS),
        .SCAN_DIV       (SCAN_DIV),
        .DEAD_CYC       (DEAD_CYC),
        .BLINK_FRAMES   (BLINK_FRAMES),
        .SEG_ACTIVE_LOW (0),
        .DIG_ACTIVE_LOW (0)
    ) dut (
        .i_time_clk    (clk),
        .i_sys_rst     (rst_n),
        .i_digits      (digits),
        .i_dp_mask     (dp_mask),
        .i_blank_lz    (blank_lz),
        .i_blink_mask  (blink_mask),
        .o_seg         (o_seg),
        .o_dp          (o_dp),
        .o_dig_en      (o_dig_en),
        .o_frame_start (o_frame_start)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic check_slot(input string name, input int slot, input logic [6:0] exp_seg, input logic exp_dp);
        check_output({name, "_seg"}, {25'd0, o_seg}, {25'd0, exp_seg});
        check_output({name, "_dp"}, {31'd0, o_dp}, {31'd0, exp_dp});
        check_output({name, "_dig_en"}, {28'd0, o_dig_en}, {28'd0, 4'b0001 << slot});
    endtask

    task automatic check_all_off(input string name);
        check_output({name, "_seg"}, {25'd0, o_seg}, 32'd0);
        check_output({name, "_dp"}, {31'd0, o_dp}, 32'd0);
        check_output({name, "_dig_en"}, {28'd0, o_dig_en}, 32'd0);
        check_output({name, "_fs"}, {31'd0, o_frame_start}, 32'd0);
    endtask

    task automatic apply_stimulus(input vec_t v);
        digits   = v.digits;
        dp_mask  = v.dp_mask;
        blank_lz = v.blank_lz;
    endtask

    initial begin
        int          sc_cyc  [12];
        int          sc_slot [12];
        logic [6:0]  sc_seg  [12];
        int          f, s, d, base;
        logic        vis;
        logic [6:0]  exp_seg;
        logic        exp_dp;

        seg_lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

        sc_cyc  = '{195, 203, 211, 219, 227, 235, 243, 251, 259, 283, 291, 323};
        sc_slot = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 3, 0, 0};
        sc_seg  = '{7'h66, 7'h4F, 7'h5B, 7'h06, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                    7'h6F, 7'h3F, 7'h6F, 7'h4F};

        vecs[0]  = '{16'h0070, 4'b0000, 1'b1, 3, 7'h00, 1'b0};
        vecs[1]  = '{16'h0070, 4'b0000, 1'b1, 2, 7'h00, 1'b0};
        vecs[2]  = '{16'h0070, 4'b0000, 1'b1, 1, 7'h07, 1'b0};
        vecs[3]  = '{16'h0070, 4'b0000, 1'b1, 0, 7'h3F, 1'b0};
        vecs[4]  = '{16'h0070, 4'b0000, 1'b0, 3, 7'h3F, 1'b0};
        vecs[5]  = '{16'h0070, 4'b0000, 1'b0, 2, 7'h3F, 1'b0};
        vecs[6]  = '{16'h000A, 4'b0100, 1'b1, 0, 7'h40, 1'b0};
        vecs[7]  = '{16'h000A, 4'b0100, 1'b1, 2, 7'h00, 1'b1};
        vecs[8]  = '{16'h000A, 4'b0100, 1'b1, 1, 7'h00, 1'b0};
        vecs[9]  = '{16'h0000, 4'b0000, 1'b1, 0, 7'h3F, 1'b0};
        vecs[10] = '{16'h0000, 4'b0000, 1'b1, 1, 7'h00, 1'b0};
        vecs[11] = '{16'h9080, 4'b0000, 1'b1, 3, 7'h6F, 1'b0};
        vecs[12] = '{16'h9080, 4'b0000, 1'b1, 2, 7'h3F, 1'b0};
        vecs[13] = '{16'h9080, 4'b0000, 1'b1, 1, 7'h7F, 1'b0};
        vecs[14] = '{16'h00B0, 4'b0001, 1'b1, 1, 7'h40, 1'b0};
        vecs[15] = '{16'h00B0, 4'b0001, 1'b1, 0, 7'h3F, 1'b1};
        vecs[16] = '{16'h00B0, 4'b0001, 1'b1, 3, 7'h00, 1'b0};
        vecs[17] = '{16'hF000, 4'b1111, 1'b0, 3, 7'h40, 1'b1};
        vecs[18] = '{16'hF000, 4'b1111, 1'b0, 0, 7'h3F, 1'b1};

        // Reset with 0x1234 waiting at the inputs, digit 0 blinking with its dp on.
        digits     = 16'h1234;
        dp_mask    = 4'b0001;
        blink_mask = 4'b0001;
        blank_lz   = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_off("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all_off("after_release");
        cyc = -1;
        next_cycle();

        // Eleven frames: dead time, frame pulses, snapshot timing and blink phases.
        for (int c = 0; c < 336; c++) begin
            wait_until(c);
            check_output("frame_start", {31'd0, o_frame_start},
                         {31'd0, ((c % FRAME) == 0) && (c > 0)});
            check_output("dig_en_scan", {28'd0, o_dig_en},
                         {28'd0, ((c % SCAN_DIV) >= DEAD_CYC) ? (4'b0001 << ((c / SCAN_DIV) % DIGITS)) : 4'b0000});
            if (c < 192 && (c % SCAN_DIV) == DEAD_CYC + 1) begin
                f       = c / FRAME;
                s       = (c / SCAN_DIV) % DIGITS;
                d       = (f == 0) ? 0 : 4 - s;
                vis     = ((f / BLINK_FRAMES) % 2) == 0;
                exp_seg = (s == 0 && !vis) ? 7'h00 : seg_lut[d];
                exp_dp  = (s == 0) ? vis : 1'b0;
                check_slot("blink_frames", s, exp_seg, exp_dp);
            end
            for (int i = 0; i < 12; i++) begin
                if (c == sc_cyc[i]) check_slot("snap_timing", sc_slot[i], sc_seg[i], 1'b0);
            end
            if (c == 191) begin
                blink_mask = 4'b0000;
                dp_mask    = 4'b0000;
            end
            if (c == 200) digits = 16'h5678;
            if (c == 254) digits = 16'h0009;
            if (c == 287) digits = 16'h0003;
        end

        // Leading-zero, dash and decimal-point vectors, each shown from a fresh snapshot.
        for (int i = 0; i < 19; i++) begin
            apply_stimulus(vecs[i]);
            base = ((cyc + 2) / FRAME + 1) * FRAME;
            wait_until(base + vecs[i].slot * SCAN_DIV + DEAD_CYC + 1);
            check_slot($sformatf("vec%0d", i), vecs[i].slot, vecs[i].exp_seg, vecs[i].exp_dp);
        end

        // Reset asserted in the middle of a lit slot.
        for (int i = 0; i < SCAN_DIV && (cyc % SCAN_DIV) != 5; i++) next_cycle();
        check_output("pre_reset_dig_en", {28'd0, o_dig_en},
                     {28'd0, 4'b0001 << ((cyc / SCAN_DIV) % DIGITS)});
        #2;
        rst_n = 1'b0;
        #1;
        check_all_off("mid_slot_reset");
        digits   = 16'h0042;
        dp_mask  = 4'b0000;
        blank_lz = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = -1;
        next_cycle();
        check_output("restart_c0_dig_en", {28'd0, o_dig_en}, 32'd0);
        check_output("restart_c0_seg", {25'd0, o_seg}, 32'h3F);
        check_output("restart_c0_fs", {31'd0, o_frame_start}, 32'd0);
        wait_until(2);
        check_output("restart_c2_dig_en", {28'd0, o_dig_en}, 32'h1);
        wait_until(8);
        check_output("restart_c8_dig_en", {28'd0, o_dig_en}, 32'h0);
        wait_until(10);
        check_slot("restart_c10", 1, 7'h3F, 1'b0);
        wait_until(31);
        check_output("restart_c31_fs", {31'd0, o_frame_start}, 32'd0);
        wait_until(32);
        check_output("restart_c32_fs", {31'd0, o_frame_start}, 32'd1);
        check_output("restart_c32_seg", {25'd0, o_seg}, 32'h5B);
        check_output("restart_c32_dig_en", {28'd0, o_dig_en}, 32'h0);
        wait_until(33);
        check_output("restart_c33_fs", {31'd0, o_frame_start}, 32'd0);
        wait_until(34);
        check_slot("restart_c34", 0, 7'h5B, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed seven-segment display driver downstream of the cascaded BCD digit counters. Captures a packed vector of BCD digits (one per counter stage), scans them one digit at a time with a per-digit dead time against ghosting, decodes each to segment patterns, and applies leading-zero blanking, decimal points and per-digit blinking. It is the last stage before the board-level display pins.

## Interface
- DIGITS, 6: number of digits scanned (2..8)
- SCAN_DIV, 50000: clock cycles per digit slot (>= DEAD_CYC+2)
- DEAD_CYC, 500: cycles at the start of each slot with all digit enables inactive
- BLINK_FRAMES, 50: frames per blink half-period (>= 1)
- SEG_ACTIVE_LOW, 1: 1 = segment/dp outputs active-low (common anode)
- DIG_ACTIVE_LOW, 1: 1 = digit enables active-low
- i_time_clk  input  1  system clock
- i_sys_rst  input  1  reset, asynchronous assert, active-low
- i_digits  input  4*DIGITS  packed BCD, digit 0 (least significant) in bits [3:0]
- i_dp_mask  input  DIGITS  decimal point on for digit k when bit k = 1
- i_blank_lz  input  1  enable leading-zero blanking
- i_blink_mask  input  DIGITS  digit k blinks when bit k = 1
- o_seg  output  7  segments, bit0 = a … bit6 = g
- o_dp  output  1  decimal point
- o_dig_en  output  DIGITS  one-hot digit enable (or all inactive)
- o_frame_start  output  1  one-cycle pulse when scan wraps to digit 0

## Operation
- State: prescaler p (0..SCAN_DIV-1), slot index s (0..DIGITS-1), snapshot register snap (4*DIGITS), frame counter f (0..BLINK_FRAMES-1), blink phase b (1 = visible).
- Each cycle p increments; at p = SCAN_DIV-1, p -> 0 and s -> s+1, wrapping DIGITS-1 -> 0.
- Frame wrap event W: p = SCAN_DIV-1 and s = DIGITS-1. On W: snap <= i_digits; f increments, and at f = BLINK_FRAMES-1 it wraps to 0 and b toggles. i_digits, i_dp_mask, i_blink_mask and i_blank_lz are used live except that digit values come only from snap; no tearing within a frame.
- Leading-zero blanking (i_blank_lz = 1): digit k is blanked if snap digits DIGITS-1 down to k are all 0; digit 0 never blanked. Blanking removes segments only; dp still follows i_dp_mask.
- Decode (active-high form, a = bit0): 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F; A–F show dash 40.
- Blink: when b = 0 and i_blink_mask[s] = 1, segments and dp of that digit are all off.
- Digit enable: one-hot at bit s when p >= DEAD_CYC, otherwise all inactive.
- Polarity: SEG_ACTIVE_LOW / DIG_ACTIVE_LOW invert the active-high forms at the output register.

## Timing
- All outputs registered; each output reflects the (p, s) state of the previous cycle (1-cycle latency).
- o_frame_start asserts for exactly one cycle, the cycle after W (first cycle o_* reflect s = 0, p = 0).
- During reset and the first cycle after release: p = 0, s = 0, snap = 0, f = 0, b = 1, o_seg and o_dp inactive, o_dig_en all inactive, o_frame_start = 0.
- First frame after reset displays snap = 0; new i_digits appear from the frame after the first W.
- Reset asserted mid-slot immediately forces all outputs inactive (asynchronous).
- Input change on the W cycle itself is captured; a change one cycle later waits a full frame.

## Structure
- seg7_pkg: 7-bit BCD-to-segment constants, dash pattern, segment bit-index constants.
- Sub-module bcd_to_seg7: combinational 4-bit BCD -> 7-bit active-high pattern; instantiated once on the muxed digit.
- Top: prescaler, slot/frame/blink counters, snapshot, LZ mask logic, output register stage.

## Test plan
Bench parameters: DIGITS=4, SCAN_DIV=8, DEAD_CYC=2, BLINK_FRAMES=2, both polarities active-high.
- Reset release, i_digits=16'h1234 -> first frame shows 0 on all digits; second frame: slot 0 seg 66, slot 1 4F, slot 2 5B, slot 3 06; o_dig_en 0 for 2 cycles then one-hot for 6 cycles per slot.
- i_digits=16'h0070, i_blank_lz=1 -> digit 3 seg 00, digit 2 seg 00, digit 1 07, digit 0 3F; with i_blank_lz=0 digits 3,2 show 3F.
- i_digits=16'h000A, i_dp_mask=4'b0100 -> digit 0 seg 40; digit 2 seg 00 (LZ) with o_dp=1.
- i_blink_mask=4'b0001 -> digit 0 visible frames 0–1 after reset, blank frames 2–3, visible 4–5; o_frame_start one pulse every 32 cycles.
- Change i_digits mid-frame -> displayed values unchanged until the following frame; assert i_sys_rst low mid-slot -> all outputs inactive same cycle, restart at s=0 p=0.
